// File: rtl/vedic64x64_seq_mul.sv
// Iterative 64x64 unsigned multiplier: one 32x32 Vedic core, four half-products accumulated into 128 bits.
// Optional macro VEDIC_SEQ_PPREG_EN registers the core output and adds an ACC3 drain state.

module vedic_core #(
  parameter int W = 32
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);
  generate
    if (W == 2) begin : g_leaf
      // 2x2 Urdhva-Tiryagbhyam: vertical, crosswise, vertical
      logic w_x0, w_x1, w_c1, w_v1;
      assign w_x0 = i_a[1] & i_b[0];
      assign w_x1 = i_a[0] & i_b[1];
      assign w_c1 = w_x0 & w_x1;
      assign w_v1 = i_a[1] & i_b[1];
      assign o_p  = {w_v1 & w_c1, w_v1 ^ w_c1, w_x0 ^ w_x1, i_a[0] & i_b[0]};
    end else begin : g_split
      localparam int H = W / 2;
      logic [W-1:0] w_q0, w_q1, w_q2, w_q3;
      logic [W:0]   w_mid;
      vedic_core #(.W(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_q0));
      vedic_core #(.W(H)) u_hl (.i_a(i_a[W-1:H]), .i_b(i_b[H-1:0]), .o_p(w_q1));
      vedic_core #(.W(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[W-1:H]), .o_p(w_q2));
      vedic_core #(.W(H)) u_hh (.i_a(i_a[W-1:H]), .i_b(i_b[W-1:H]), .o_p(w_q3));
      assign w_mid = {1'b0, w_q1} + {1'b0, w_q2};
      assign o_p   = {w_q3, w_q0} + ({{(W-1){1'b0}}, w_mid} << H);
    end
  endgenerate
endmodule

module vedic64x64_seq_mul #(
  parameter int ID_W        = 4,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_a,
  input  logic [63:0]     in_b,
  input  logic [ID_W-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_p,
  output logic [ID_W-1:0] out_tag,
  output logic            busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_MUL3,
`ifdef VEDIC_SEQ_PPREG_EN
    S_ACC3,
`endif
    S_DONE
  } state_t;

  state_t          r_state;
  logic [63:0]     r_a, r_b;
  logic [ID_W-1:0] r_tag, r_out_tag;
  logic [127:0]    r_acc, r_out_p;
  logic            r_out_valid;

  logic [31:0]     w_ca, w_cb;
  logic [63:0]     w_pp;
  logic [127:0]    w_add, w_sum;
  logic            w_accept, w_zero;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_zero    = ZERO_BYPASS & ((in_a == 64'd0) | (in_b == 64'd0));
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_tag   = r_out_tag;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_ca = r_a[31:0];
    w_cb = r_b[31:0];
    case (r_state)
      S_MUL1:  w_ca = r_a[63:32];
      S_MUL2:  w_cb = r_b[63:32];
      S_MUL3:  begin w_ca = r_a[63:32]; w_cb = r_b[63:32]; end
      default: ;
    endcase
  end

  vedic_core #(.W(32)) u_core (.i_a(w_ca), .i_b(w_cb), .o_p(w_pp));

`ifdef VEDIC_SEQ_PPREG_EN
  // Each state adds the previous step's registered half-product.
  logic [63:0] r_pp;
  always_comb begin
    w_add = '0;
    case (r_state)
      S_MUL1:         w_add = {64'd0, r_pp};
      S_MUL2, S_MUL3: w_add = {32'd0, r_pp, 32'd0};
      S_ACC3:         w_add = {r_pp, 64'd0};
      default:        ;
    endcase
  end
`else
  always_comb begin
    w_add = '0;
    case (r_state)
      S_MUL0:         w_add = {64'd0, w_pp};
      S_MUL1, S_MUL2: w_add = {32'd0, w_pp, 32'd0};
      S_MUL3:         w_add = {w_pp, 64'd0};
      default:        ;
    endcase
  end
`endif

  assign w_sum = r_acc + w_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_acc       <= '0;
      r_out_p     <= '0;
      r_out_tag   <= '0;
      r_out_valid <= 1'b0;
`ifdef VEDIC_SEQ_PPREG_EN
      r_pp        <= '0;
`endif
    end else begin
`ifdef VEDIC_SEQ_PPREG_EN
      r_pp <= w_pp;
`endif
      if ((r_state == S_DONE) && out_ready)
        r_out_valid <= 1'b0;
      if (w_accept) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_tag <= in_tag;
        r_acc <= '0;
        if (w_zero) begin
          // zero operand: result is known, skip the core entirely
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_out_p     <= '0;
          r_out_tag   <= in_tag;
        end else begin
          r_state <= S_MUL0;
        end
      end else begin
        case (r_state)
          S_MUL0: begin r_acc <= w_sum; r_state <= S_MUL1; end
          S_MUL1: begin r_acc <= w_sum; r_state <= S_MUL2; end
          S_MUL2: begin r_acc <= w_sum; r_state <= S_MUL3; end
`ifdef VEDIC_SEQ_PPREG_EN
          S_MUL3: begin r_acc <= w_sum; r_state <= S_ACC3; end
          S_ACC3: begin
`else
          S_MUL3: begin
`endif
            r_out_p     <= w_sum;
            r_out_tag   <= r_tag;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
          S_DONE:  if (out_ready) r_state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vedic64x64_seq_mul.sv
// Self-checking bench for vedic64x64_seq_mul: directed scenarios plus a random
// handshake stream scored against a plain-arithmetic product model.
module tb_vedic64x64_seq_mul;
`ifdef VEDIC_SEQ_PPREG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif
  localparam int NOPS = 3000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [63:0]  in_a = '0, in_b = '0;
  logic [3:0]   in_tag = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [127:0] out_p;
  logic [3:0]   out_tag;
  logic         busy;

  logic         nb_in_valid = 1'b0, nb_in_ready;
  logic [63:0]  nb_in_a = '0, nb_in_b = '0;
  logic [3:0]   nb_in_tag = '0;
  logic         nb_out_valid, nb_out_ready = 1'b0;
  logic [127:0] nb_out_p;
  logic [3:0]   nb_out_tag;
  logic         nb_busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vedic64x64_seq_mul #(.ID_W(4), .ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag), .busy(busy));

  vedic64x64_seq_mul #(.ID_W(4), .ZERO_BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(nb_in_valid), .in_ready(nb_in_ready),
    .in_a(nb_in_a), .in_b(nb_in_b), .in_tag(nb_in_tag), .out_valid(nb_out_valid),
    .out_ready(nb_out_ready), .out_p(nb_out_p), .out_tag(nb_out_tag), .busy(nb_busy));

  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b);
    return 128'(a) * 128'(b);
  endfunction

  // Issue one op with out_ready low; lat counts edges from the accept edge (inclusive).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t,
                        output int lat);
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
    checks++; if (out_p !== 128'd0) $display("FAIL reset_out_p got=%h want=0", out_p); else passed++;
    checks++; if (out_tag !== 4'd0) $display("FAIL reset_out_tag got=%h want=0", out_tag); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max;
    int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, lat);
    checks++; if (lat != LAT) $display("FAIL max_latency got=%0d want=%0d", lat, LAT); else passed++;
    checks++; if (out_p !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001)
      $display("FAIL max_product got=%h want=fffffffffffffffe0000000000000001", out_p); else passed++;
    checks++; if (out_tag !== 4'd3) $display("FAIL max_tag got=%h want=3", out_tag); else passed++;
    drain();
  endtask

  task automatic test_patterns;
    logic [63:0] va[6];
    logic [63:0] vb[6];
    int lat;
    va[0] = 64'h0000_0001_0000_0000; vb[0] = 64'h2;
    va[1] = 64'h1234_5678_9ABC_DEF0; vb[1] = 64'h0FED_CBA9_8765_4321;
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0001;
    for (int i = 3; i < 6; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
    end
    run_op(va[0], vb[0], 4'd1, lat);
    checks++; if (out_p !== 128'h2_0000_0000) $display("FAIL shift_product got=%h want=200000000", out_p); else passed++;
    drain();
    for (int i = 1; i < 6; i++) begin
      run_op(va[i], vb[i], 4'(i), lat);
      checks++; if (out_p !== model(va[i], vb[i]))
        $display("FAIL pattern%0d_product got=%h want=%h", i, out_p, model(va[i], vb[i])); else passed++;
      checks++; if (lat != LAT) $display("FAIL pattern%0d_latency got=%0d want=%0d", i, lat, LAT); else passed++;
      drain();
    end
  endtask

  task automatic test_bypass;
    int lat;
    run_op(64'd0, 64'hDEAD, 4'd5, lat);
    checks++; if (lat != 1) $display("FAIL bypass_a0_latency got=%0d want=1", lat); else passed++;
    checks++; if (out_p !== 128'd0) $display("FAIL bypass_a0_product got=%h want=0", out_p); else passed++;
    checks++; if (out_tag !== 4'd5) $display("FAIL bypass_a0_tag got=%h want=5", out_tag); else passed++;
    drain();
    run_op(64'h77, 64'd0, 4'd6, lat);
    checks++; if (lat != 1) $display("FAIL bypass_b0_latency got=%0d want=1", lat); else passed++;
    drain();
    nb_in_a = 64'd0; nb_in_b = 64'hDEAD; nb_in_tag = 4'd7; nb_in_valid = 1'b1; nb_out_ready = 1'b0;
    @(posedge clk); #1;
    nb_in_valid = 1'b0;
    lat = 1;
    while (!nb_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != LAT) $display("FAIL nobypass_latency got=%0d want=%0d", lat, LAT); else passed++;
    checks++; if (nb_out_p !== 128'd0) $display("FAIL nobypass_product got=%h want=0", nb_out_p); else passed++;
    checks++; if (nb_out_tag !== 4'd7) $display("FAIL nobypass_tag got=%h want=7", nb_out_tag); else passed++;
    nb_out_ready = 1'b1;
    @(posedge clk); #1;
    nb_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] a1, b1, a2, b2;
    int lat, bad;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom} | 64'h1;
    a2 = {$urandom, $urandom} | 64'h1; b2 = {$urandom, $urandom};
    run_op(a1, b1, 4'hA, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_p !== model(a1, b1) || out_tag !== 4'hA || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) $display("FAIL hold_stable got=%0d bad cycles want=0", bad); else passed++;
    in_a = a2; in_b = b2; in_tag = 4'hB; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%b want=1", in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_accept got valid=%b busy=%b want valid=0 busy=1", out_valid, busy); else passed++;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != LAT) $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); else passed++;
    checks++; if (out_p !== model(a2, b2)) $display("FAIL b2b_product got=%h want=%h", out_p, model(a2, b2)); else passed++;
    checks++; if (out_tag !== 4'hB) $display("FAIL b2b_tag got=%h want=b", out_tag); else passed++;
    drain();
  endtask

  task automatic test_reset_mid;
    int seen;
    in_a = 64'h0123_4567_89AB_CDEF; in_b = 64'hFEDC_BA98_7654_3210; in_tag = 4'h9;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got=%b want=0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got=%b want=0", busy); else passed++;
    checks++; if (out_p !== 128'd0) $display("FAIL midreset_out_p got=%h want=0", out_p); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready got=%b want=1", in_ready); else passed++;
    out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checks++; if (seen != 0) $display("FAIL midreset_ghost got=%0d results want=0", seen); else passed++;
  endtask

  task automatic test_stream;
    logic [127:0] qp[$];
    logic [3:0]   qt[$];
    logic [127:0] ep;
    logic [3:0]   et;
    int sent, got, cyc, errs;
    sent = 0; got = 0; cyc = 0; errs = 0;
    while ((sent < NOPS || qp.size() > 0) && cyc < 60000) begin
      if (sent < NOPS && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) in_a = 64'd0;
        if ($urandom_range(0, 15) == 0) in_b = 64'd0;
        if ($urandom_range(0, 15) == 0) in_a = '1;
        in_tag = 4'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        if (qp.size() == 0) begin
          checks++; errs++;
          $display("FAIL stream_unexpected got=%h tag=%h want=no result", out_p, out_tag);
        end else begin
          ep = qp.pop_front();
          et = qt.pop_front();
          checks++; if (out_p !== ep) begin errs++; $display("FAIL stream_product got=%h want=%h", out_p, ep); end else passed++;
          checks++; if (out_tag !== et) begin errs++; $display("FAIL stream_tag got=%h want=%h", out_tag, et); end else passed++;
        end
      end
      if (in_valid && in_ready) begin
        qp.push_back(model(in_a, in_b));
        qt.push_back(in_tag);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != NOPS || qp.size() != 0)
      $display("FAIL stream_count got=%0d results (%0d pending) want=%0d", got, qp.size(), NOPS); else passed++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_max();
    test_patterns();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
